// File: rtl/timer_irq_arbiter.sv
// timer_irq_arbiter: gathers the CMIA/CMIB/OVI flags of timer channels 0..3
// into one CPU interrupt request with a req/ack handshake, followed by a
// one-hot clear pulse back to the timer.
// Optional feature macro: TIMER_IRQ_RR_EN selects round-robin arbitration.
// When the macro is undefined, the lowest pending index wins.
module timer_irq_arbiter #(
   parameter int NUM_SRC  = 12,
   parameter int ID_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  irq_src,
   input  logic [NUM_SRC-1:0]  irq_mask,
   input  logic                irq_ack,
   output logic                irq_req,
   output logic [ID_WIDTH-1:0] irq_id,
   output logic [NUM_SRC-1:0]  irq_clr,
   output logic [NUM_SRC-1:0]  irq_pending
);

   typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_t;

   state_t                state_q, state_d;
   logic [NUM_SRC-1:0]    src_d, pending, eligible;
   logic                  win_vld;
   logic [ID_WIDTH-1:0]   win_id;
   logic                  req_d;
   logic [ID_WIDTH-1:0]   id_d;
   logic [NUM_SRC-1:0]    clr_d;

   assign eligible    = pending & ~irq_mask;
   assign irq_pending = pending;

   // Edge latch. A new rising edge beats the clear pulse for the same bit,
   // so a flag that re-fires during service is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_d   <= '0;
         pending <= '0;
      end else begin
         src_d   <= irq_src;
         pending <= (pending & ~irq_clr) | (irq_src & ~src_d);
      end
   end

`ifdef TIMER_IRQ_RR_EN
   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_SRC - 1);

   logic [ID_WIDTH-1:0]  rr_ptr;
   logic [2*NUM_SRC-1:0] dbl;
   logic [NUM_SRC-1:0]   rot;

   // Round-robin pointer: moves past the serviced source only when it is
   // actually cleared; a withdrawn grant leaves it where it was.
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (state_q == CLEAR)
         rr_ptr <= (irq_id == LAST_ID) ? '0 : irq_id + ID_WIDTH'(1);
   end

   // Rotate eligible so rr_ptr lands on bit 0, then take the first set bit
   // and map its position back to a source index.
   always_comb begin
      int sum;
      dbl     = {eligible, eligible} >> rr_ptr;
      rot     = dbl[NUM_SRC-1:0];
      win_vld = 1'b0;
      win_id  = '0;
      sum     = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!win_vld && rot[i]) begin
            win_vld = 1'b1;
            sum     = int'(rr_ptr) + i;
            if (sum >= NUM_SRC) sum = sum - NUM_SRC;
            win_id  = ID_WIDTH'(sum);
         end
      end
   end
`else
   // Fixed priority: lowest eligible index wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!win_vld && eligible[i]) begin
            win_vld = 1'b1;
            win_id  = ID_WIDTH'(i);
         end
      end
   end
`endif

   // Handshake state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         irq_req <= 1'b0;
         irq_id  <= '0;
         irq_clr <= '0;
      end else begin
         state_q <= state_d;
         irq_req <= req_d;
         irq_id  <= id_d;
         irq_clr <= clr_d;
      end
   end

   // Next state: the winner is chosen only from IDLE, so nothing preempts a
   // grant already presented; ack beats a same-cycle mask of the grant.
   always_comb begin
      state_d = state_q;
      req_d   = irq_req;
      id_d    = irq_id;
      clr_d   = '0;
      case (state_q)
         IDLE: begin
            req_d = 1'b0;
            if (win_vld) begin
               state_d = REQ;
               req_d   = 1'b1;
               id_d    = win_id;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_d = CLEAR;
               req_d   = 1'b0;
               clr_d   = NUM_SRC'(1) << irq_id;
            end else if (irq_mask[irq_id]) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         CLEAR: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_timer_irq_arbiter.sv
// Bench for timer_irq_arbiter: a vector table for the basic handshake and
// ordering, hand sequences for withdraw, set-wins and reset, plus a grant
// scoreboard fed when stimulus is driven and drained on each new irq_req.
module tb_timer_irq_arbiter;

`ifdef TIMER_IRQ_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] irq_src, irq_mask, irq_clr, irq_pending;
   logic        irq_ack, irq_req;
   logic [3:0]  irq_id;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   logic prev_req = 1'b0;

   timer_irq_arbiter #(.NUM_SRC(12), .ID_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .irq_src(irq_src), .irq_mask(irq_mask),
      .irq_ack(irq_ack), .irq_req(irq_req), .irq_id(irq_id),
      .irq_clr(irq_clr), .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] src;
      logic [11:0] mask;
      logic        ack;
      logic        req;
      logic [3:0]  id;
      logic [11:0] clr;
      logic [11:0] pend;
      bit          p0_en;
      int          p0;
      bit          p1_en;
      int          p1;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int max);
      int n = 0;
      while (!irq_req && n < max) begin
         tick();
         n++;
      end
      chk("req_timeout", {31'd0, irq_req}, 32'd1);
   endtask

   // Scoreboard: every rising irq_req must match the next expected grant.
   always begin
      @(posedge clk);
      #1;
      if (irq_req && !prev_req) begin
         if (exp_q.size() == 0) begin
            chk("grant_unexpected", {28'd0, irq_id}, 32'hffff_ffff);
         end else begin
            chk("grant_id", {28'd0, irq_id}, exp_q.pop_front());
         end
      end
      prev_req = irq_req;
   end

   function automatic vec_t mk(input logic [11:0] src, input logic ack, input logic req,
                               input logic [3:0] id, input logic [11:0] clr, input logic [11:0] pend);
      vec_t v;
      v.src = src; v.mask = 12'h000; v.ack = ack; v.req = req; v.id = id;
      v.clr = clr; v.pend = pend; v.p0_en = 1'b0; v.p0 = 0; v.p1_en = 1'b0; v.p1 = 0;
      return v;
   endfunction

   initial begin
      int f, s;
      f = RR ? 5 : 1;
      s = RR ? 1 : 5;
      // single OVI0 source, then stray ack in IDLE, then bits 5 and 1 together
      vecs[0]  = mk(12'h004, 0, 0, 0, 12'h000, 12'h004); vecs[0].p0_en = 1; vecs[0].p0 = 2;
      vecs[1]  = mk(12'h000, 0, 1, 2, 12'h000, 12'h004);
      vecs[2]  = mk(12'h000, 1, 0, 0, 12'h004, 12'h004);
      vecs[3]  = mk(12'h000, 0, 0, 0, 12'h000, 12'h000);
      vecs[4]  = mk(12'h000, 1, 0, 0, 12'h000, 12'h000);
      vecs[5]  = mk(12'h000, 0, 0, 0, 12'h000, 12'h000);
      vecs[6]  = mk(12'h022, 0, 0, 0, 12'h000, 12'h022);
      vecs[6].p0_en = 1; vecs[6].p0 = f; vecs[6].p1_en = 1; vecs[6].p1 = s;
      vecs[7]  = mk(12'h000, 0, 1, 4'(f), 12'h000, 12'h022);
      vecs[8]  = mk(12'h000, 1, 0, 0, 12'h001 << f, 12'h022);
      vecs[9]  = mk(12'h000, 0, 0, 0, 12'h000, 12'h001 << s);
      vecs[10] = mk(12'h000, 0, 1, 4'(s), 12'h000, 12'h001 << s);
      vecs[11] = mk(12'h000, 1, 0, 0, 12'h001 << s, 12'h001 << s);
      vecs[12] = mk(12'h000, 0, 0, 0, 12'h000, 12'h000);

      rst = 1'b1; irq_src = '0; irq_mask = '0; irq_ack = 1'b0;
      tick(); tick();
      chk("rst_req", {31'd0, irq_req}, 32'd0);
      chk("rst_id", {28'd0, irq_id}, 32'd0);
      chk("rst_clr", {20'd0, irq_clr}, 32'd0);
      chk("rst_pend", {20'd0, irq_pending}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         irq_src = vecs[i].src; irq_mask = vecs[i].mask; irq_ack = vecs[i].ack;
         if (vecs[i].p0_en) exp_q.push_back(vecs[i].p0);
         if (vecs[i].p1_en) exp_q.push_back(vecs[i].p1);
         tick();
         chk($sformatf("vec%0d_req", i), {31'd0, irq_req}, {31'd0, vecs[i].req});
         if (vecs[i].req) chk($sformatf("vec%0d_id", i), {28'd0, irq_id}, {28'd0, vecs[i].id});
         chk($sformatf("vec%0d_clr", i), {20'd0, irq_clr}, {20'd0, vecs[i].clr});
         chk($sformatf("vec%0d_pend", i), {20'd0, irq_pending}, {20'd0, vecs[i].pend});
      end
      irq_ack = 1'b0; irq_src = '0;

      // mask withdraw on id 7, then re-request after unmask
      irq_src = 12'h080; exp_q.push_back(7); tick();
      irq_src = 12'h000; tick();
      chk("wd_req", {31'd0, irq_req}, 32'd1);
      chk("wd_id", {28'd0, irq_id}, 32'd7);
      irq_mask = 12'h080; tick();
      chk("wd_drop", {31'd0, irq_req}, 32'd0);
      chk("wd_pend", {31'd0, irq_pending[7]}, 32'd1);
      tick();
      chk("wd_masked", {31'd0, irq_req}, 32'd0);
      irq_mask = 12'h000; exp_q.push_back(7);
      wait_req(4);
      chk("wd_reid", {28'd0, irq_id}, 32'd7);
      irq_ack = 1'b1; tick();
      chk("wd_clr", {20'd0, irq_clr}, 32'h080);
      irq_ack = 1'b0; tick();
      chk("wd_pend0", {20'd0, irq_pending}, 32'd0);

      // set-wins: new edge on bit 4 during its own CLEAR cycle
      irq_src = 12'h010; exp_q.push_back(4); tick();
      irq_src = 12'h000; tick();
      chk("sw_id", {28'd0, irq_id}, 32'd4);
      irq_ack = 1'b1; tick();
      chk("sw_clr", {20'd0, irq_clr}, 32'h010);
      irq_ack = 1'b0; irq_src = 12'h010; exp_q.push_back(4); tick();
      chk("sw_clr_end", {20'd0, irq_clr}, 32'd0);
      chk("sw_pend", {20'd0, irq_pending}, 32'h010);
      irq_src = 12'h000;
      wait_req(4);
      chk("sw_reid", {28'd0, irq_id}, 32'd4);
      irq_ack = 1'b1; tick();
      irq_ack = 1'b0; tick();
      chk("sw_pend0", {20'd0, irq_pending}, 32'd0);

      // reset mid-handshake, source 0 held high through release
      irq_src = 12'h200; exp_q.push_back(9); tick();
      irq_src = 12'h000; tick();
      chk("rs_req", {31'd0, irq_req}, 32'd1);
      rst = 1'b1; irq_src = 12'h001; tick();
      chk("rs_req0", {31'd0, irq_req}, 32'd0);
      chk("rs_clr0", {20'd0, irq_clr}, 32'd0);
      chk("rs_pend0", {20'd0, irq_pending}, 32'd0);
      tick();
      rst = 1'b0; exp_q.push_back(0); tick();
      chk("rel_t0_req", {31'd0, irq_req}, 32'd0);
      chk("rel_t0_pend", {20'd0, irq_pending}, 32'h001);
      tick();
      chk("rel_t1_req", {31'd0, irq_req}, 32'd1);
      chk("rel_t1_id", {28'd0, irq_id}, 32'd0);
      irq_ack = 1'b1; tick();
      chk("rel_clr", {20'd0, irq_clr}, 32'h001);
      irq_ack = 1'b0; irq_src = 12'h000; tick(); tick();
      chk("end_pend", {20'd0, irq_pending}, 32'd0);
      chk("end_req", {31'd0, irq_req}, 32'd0);
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
